pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Receive-side counterpart of the PWM output stage: measures an incoming PWM waveform.
//  Reports high time, period and an 8-bit duty value on the same 0..255 scale as the
//  driver's cutoff (duty = high*256/period). Sits between an external pin and the
//  processor's I/O register file; a driver output can be looped back into it for self-test.
// PARAMETERS
//  CNT_W        16       width of high/period counters (clk cycles)
//  TIMEOUT      16'hFFFF cycles without an edge before line is declared stuck
//  SYNC_STAGES  2        input synchronizer depth (>=2)
// PORTS
//  clk           in   1      single clock, all logic rising-edge
//  reset         in   1      asynchronous, active-high; clears all state
//  enable        in   1      0: FSM held in IDLE, counters cleared, outputs hold last value
//  pwm_in        in   1      asynchronous PWM input
//  high_count    out  CNT_W  cycles pwm was high in last complete period
//  period_count  out  CNT_W  cycles rising-edge to rising-edge, last complete period
//  duty_value    out  8      floor(high_count*256/period_count), saturated to 255
//  sample_valid  out  1      1-cycle pulse: all three outputs updated this cycle
//  stuck         out  1      1 while line has had no edge for TIMEOUT cycles
//  stuck_level   out  1      synchronized level of line while stuck
//  overrun       out  1      sticky; period completed while divider busy; cleared by reset
// BEHAVIOUR
//  Reset values: all outputs 0; FSM IDLE; divider idle.
//  Input: SYNC_STAGES flops then 1 edge-detect flop; rise/fall pulses lag pwm_in by
//   SYNC_STAGES+1 clks. No glitch filter; every synchronized edge counts.
//  FSM (states IDLE, MEAS_HIGH, MEAS_LOW):
//   IDLE: wait rise -> MEAS_HIGH, hi_cnt=1, per_cnt=1. First partial period never reported.
//   MEAS_HIGH: hi_cnt++, per_cnt++; fall -> MEAS_LOW.
//   MEAS_LOW: per_cnt++; rise -> latch hi_cnt/per_cnt into divider, restart both at 1,
//    -> MEAS_HIGH. Measurement continues in parallel with division.
//   Rise and fall in same cycle impossible (single synchronized bit).
//  Counters saturate at all-ones; no wrap.
//  Timeout: edge-free counter (reset on any edge) reaching TIMEOUT -> stuck=1,
//   stuck_level=sync level, FSM -> IDLE, sample_valid pulse with high_count=0,
//   period_count=0, duty_value=255 if level 1 else 0. stuck clears on next edge.
//  Divider: restoring, CNT_W+8 iterations, 1 bit/clk; start->done = CNT_W+9 clks.
//   On done: outputs registered, sample_valid=1 next cycle. Quotient >255 -> 255.
//   period=0 cannot reach divider. Start while busy -> request dropped, overrun=1,
//   in-progress result still delivered.
//  Timeout and divider-done same cycle: divider result first, stuck pulse next cycle.
//  enable 1->0 mid-measurement: partial period discarded; running division completes.
//  reset mid-operation: async clear, no sample_valid emitted.
// STRUCTURE
//  Package pwm_pkg: typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} cap_state_t;
//   localparam DUTY_W = 8. Shared with the driver.
//  Sub-module seq_divider #(N_W=CNT_W+8, D_W=CNT_W): start/busy/done handshake,
//   dividend {high,8'b0}, divisor period. Top holds sync, edge detect, FSM, timeout.
// TESTING
//  1. 25% duty, period 100 clks (25 hi/75 lo), 3 periods -> 2 sample_valid pulses,
//     high_count=25, period_count=100, duty_value=64.
//  2. Loop back pwm_driver out (cutoff 'h7f) -> duty_value 127 or 128 every sample.
//  3. Hold pwm_in=1 for TIMEOUT+10 clks (TIMEOUT=200) -> stuck=1, stuck_level=1,
//     duty_value=255; then toggle -> stuck=0, normal samples resume.
//  4. Period 10 clks (< CNT_W+9=25 divide latency) -> overrun=1, results still
//     self-consistent (duty 128 for 5/5).
//  5. Assert reset mid-MEAS_LOW -> all outputs 0 same cycle; first sample after release
//     only after a full period.
//  6. High 1 clk of period 300 -> duty_value=0; high 299 of 300 -> 255.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM driver/capture pair
// Contents:
//   cap_state_t  capture FSM states
//   DUTY_W       width of the duty/cutoff scale (0..255)
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEAS_HIGH,
        MEAS_LOW
    } cap_state_t;

    localparam int DUTY_W = 8;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock
// Ports:
//   clk, rst_i          clock, asynchronous active-high reset
//   start_i             load operands when idle; ignored while busy
//   dividend_i [N_W]    numerator
//   divisor_i  [D_W]    denominator, must be non-zero
//   busy_o              division in progress
//   done_o              1-cycle pulse, quotient_o valid this cycle
//   quotient_o [N_W]    floor(dividend/divisor)
module seq_divider #(
    parameter int N_W = 24,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [N_W-1:0] dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [N_W-1:0] quotient_o
);

    localparam int C_W = $clog2(N_W + 1);

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [C_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0] quo_q, quo_d;
    logic [D_W-1:0] rem_q, rem_d;
    logic [D_W-1:0] dvs_q, dvs_d;
    logic [D_W:0]   rem_shift;

    // quo_q starts as the dividend and is shifted out MSB-first into the
    // partial remainder while quotient bits shift in from the bottom.
    // One extra cycle after the last iteration raises done.
    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        rem_shift = {rem_q, quo_q[N_W-1]};
        if (busy_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - C_W'(1);
                if (rem_shift >= {1'b0, dvs_q}) begin
                    rem_d = D_W'(rem_shift - {1'b0, dvs_q});
                    quo_d = {quo_q[N_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[D_W-1:0];
                    quo_d = {quo_q[N_W-2:0], 1'b0};
                end
            end else begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = C_W'(N_W);
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time, period and duty of an incoming PWM line
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   enable          0 holds the FSM in IDLE with counters cleared; outputs hold
//   pwm_in          asynchronous PWM input
//   high_count      high cycles of last complete period
//   period_count    rise-to-rise cycles of last complete period
//   duty_value      floor(high*256/period), saturated to 255
//   sample_valid    1-cycle pulse when the three results update
//   stuck           line has had no edge for TIMEOUT cycles
//   stuck_level     synchronized line level while stuck
//   overrun         sticky: a period completed while the divider was busy
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 16'hFFFF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  high_count,
    output logic [CNT_W-1:0]  period_count,
    output logic [DUTY_W-1:0] duty_value,
    output logic              sample_valid,
    output logic              stuck,
    output logic              stuck_level,
    output logic              overrun
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int Q_W  = CNT_W + DUTY_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_lvl, rise, fall, any_edge;

    cap_state_t             state_q, state_d;
    logic [CNT_W-1:0]       hi_q, hi_d, per_q, per_d;
    logic                   meas_done;

    logic [TO_W-1:0]        idle_q, idle_d;
    logic                   timeout_hit;

    logic                   div_busy, div_done;
    logic [Q_W-1:0]         div_quo;
    logic [CNT_W-1:0]       hi_lat_q, hi_lat_d, per_lat_q, per_lat_d;
    logic [DUTY_W-1:0]      duty_sat;

    logic [CNT_W-1:0]       hc_q, hc_d, pc_q, pc_d;
    logic [DUTY_W-1:0]      duty_q, duty_d;
    logic                   valid_q, valid_d;
    logic                   stuck_q, stuck_d, lvl_q, lvl_d;
    logic                   pend_q, pend_d;
    logic                   ovr_q, ovr_d;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~prev_q;
    assign fall     = ~sync_lvl & prev_q;
    assign any_edge = rise | fall;

    // Fires once per stuck episode; stuck_q blocks re-triggering until an edge.
    assign timeout_hit = enable && !any_edge && !stuck_q &&
                         (idle_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        idle_d = idle_q;
        if (!enable || any_edge) begin
            idle_d = '0;
        end else if (idle_q != TO_W'(TIMEOUT)) begin
            idle_d = idle_q + TO_W'(1);
        end
    end

    // Counters include the rise cycle itself, so a rise-to-rise span of N
    // clocks reports N; the fall cycle already belongs to the low phase.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        per_d     = per_q;
        meas_done = 1'b0;
        if (!enable || timeout_hit) begin
            state_d = IDLE;
            hi_d    = '0;
            per_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        hi_d    = CNT_W'(1);
                        per_d   = CNT_W'(1);
                    end
                end
                MEAS_HIGH: begin
                    per_d = sat_inc(per_q);
                    if (fall) begin
                        state_d = MEAS_LOW;
                    end else begin
                        hi_d = sat_inc(hi_q);
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        meas_done = 1'b1;
                        state_d   = MEAS_HIGH;
                        hi_d      = CNT_W'(1);
                        per_d     = CNT_W'(1);
                    end else begin
                        per_d = sat_inc(per_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    seq_divider #(
        .N_W(Q_W),
        .D_W(CNT_W)
    ) u_div (
        .clk        (clk),
        .rst_i      (reset),
        .start_i    (meas_done),
        .dividend_i ({hi_q, {DUTY_W{1'b0}}}),
        .divisor_i  (per_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    assign duty_sat = (|div_quo[Q_W-1:DUTY_W]) ? {DUTY_W{1'b1}} : div_quo[DUTY_W-1:0];

    // The divider only reports the quotient, so the operands are kept here
    // for the matching high/period outputs.
    always_comb begin
        hi_lat_d  = hi_lat_q;
        per_lat_d = per_lat_q;
        ovr_d     = ovr_q;
        if (meas_done) begin
            if (div_busy) begin
                ovr_d = 1'b1;
            end else begin
                hi_lat_d  = hi_q;
                per_lat_d = per_q;
            end
        end
    end

    always_comb begin
        stuck_d = stuck_q;
        lvl_d   = lvl_q;
        if (any_edge) begin
            stuck_d = 1'b0;
            lvl_d   = 1'b0;
        end else if (timeout_hit) begin
            stuck_d = 1'b1;
            lvl_d   = sync_lvl;
        end
    end

    // A divider result wins the output registers; a stuck report that
    // collides with it is parked in pend_q and emitted the next cycle.
    always_comb begin
        hc_d    = hc_q;
        pc_d    = pc_q;
        duty_d  = duty_q;
        valid_d = 1'b0;
        pend_d  = pend_q;
        if (div_done) begin
            hc_d    = hi_lat_q;
            pc_d    = per_lat_q;
            duty_d  = duty_sat;
            valid_d = 1'b1;
            pend_d  = pend_q | timeout_hit;
        end else if (timeout_hit || pend_q) begin
            hc_d    = '0;
            pc_d    = '0;
            duty_d  = (timeout_hit ? sync_lvl : lvl_q) ? {DUTY_W{1'b1}} : '0;
            valid_d = 1'b1;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            state_q   <= IDLE;
            hi_q      <= '0;
            per_q     <= '0;
            idle_q    <= '0;
            hi_lat_q  <= '0;
            per_lat_q <= '0;
            hc_q      <= '0;
            pc_q      <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            lvl_q     <= 1'b0;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q    <= sync_lvl;
            state_q   <= state_d;
            hi_q      <= hi_d;
            per_q     <= per_d;
            idle_q    <= idle_d;
            hi_lat_q  <= hi_lat_d;
            per_lat_q <= per_lat_d;
            hc_q      <= hc_d;
            pc_q      <= pc_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
            lvl_q     <= lvl_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
        end
    end

    assign high_count   = hc_q;
    assign period_count = pc_q;
    assign duty_value   = duty_q;
    assign sample_valid = valid_q;
    assign stuck        = stuck_q;
    assign stuck_level  = lvl_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        reset, enable, pwm_in;
    logic [15:0] hc_a, pc_a, hc_b, pc_b;
    logic [7:0]  duty_a, duty_b;
    logic        sv_a, st_a, sl_a, ov_a;
    logic        sv_b, st_b, sl_b, ov_b;

    always #5 clk = ~clk;

    // Short timeout instance for the stuck-line tests.
    pwm_capture #(.CNT_W(16), .TIMEOUT(200), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
        .high_count(hc_a), .period_count(pc_a), .duty_value(duty_a),
        .sample_valid(sv_a), .stuck(st_a), .stuck_level(sl_a), .overrun(ov_a)
    );

    // Long timeout instance so 300-cycle periods with a 299-cycle gap are measurable.
    pwm_capture #(.CNT_W(16), .TIMEOUT(1000), .SYNC_STAGES(2)) u_dut_long (
        .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
        .high_count(hc_b), .period_count(pc_b), .duty_value(duty_b),
        .sample_valid(sv_b), .stuck(st_b), .stuck_level(sl_b), .overrun(ov_b)
    );

    int checks = 0;
    int errors = 0;
    int n_a = 0;
    int n_b = 0;
    bit arm_a = 1'b0;
    bit arm_b = 1'b0;
    int exp_hi = 0;
    int exp_per = 1;
    bit exp_stuck = 1'b0;
    bit exp_lvl = 1'b0;

    function automatic int model_duty(input int h, input int p);
        int d;
        d = (h * 256) / p;
        return (d > 255) ? 255 : d;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_sample(input string tag, input int hc, input int pc,
                                input int duty, input int st);
        if (exp_stuck) begin
            chk({tag, "_stuck_hc"}, hc, 0);
            chk({tag, "_stuck_pc"}, pc, 0);
            chk({tag, "_stuck_duty"}, duty, exp_lvl ? 255 : 0);
            chk({tag, "_stuck_flag"}, st, 1);
        end else begin
            chk({tag, "_high"}, hc, exp_hi);
            chk({tag, "_period"}, pc, exp_per);
            chk({tag, "_duty"}, duty, model_duty(exp_hi, exp_per));
        end
    endtask

    always @(negedge clk) begin
        if (arm_a && sv_a === 1'b1) begin
            n_a++;
            check_sample("a", int'(hc_a), int'(pc_a), int'(duty_a), int'(st_a));
        end
        if (arm_b && sv_b === 1'b1) begin
            n_b++;
            check_sample("b", int'(hc_b), int'(pc_b), int'(duty_b), int'(st_b));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_pwm(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            step(hi);
            pwm_in = 1'b0;
            step(lo);
        end
    endtask

    task automatic gap();
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        step(1);
        n_a = 0;
        n_b = 0;
    endtask

    task automatic set_exp(input int h, input int p);
        exp_hi  = h;
        exp_per = p;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        step(3);
        chk("rst_high", int'(hc_a), 0);
        chk("rst_period", int'(pc_a), 0);
        chk("rst_duty", int'(duty_a), 0);
        chk("rst_valid", int'(sv_a), 0);
        chk("rst_stuck", int'(st_a), 0);
        chk("rst_level", int'(sl_a), 0);
        chk("rst_overrun", int'(ov_a), 0);
        reset = 1'b0;
        step(2);

        // 25% duty, period 100: first partial period is never reported.
        arm_a = 1'b1;
        gap();
        set_exp(25, 100);
        run_pwm(25, 75, 3);
        step(40);
        chk("t1_count", n_a, 2);
        chk("t1_high", int'(hc_a), 25);
        chk("t1_period", int'(pc_a), 100);
        chk("t1_duty", int'(duty_a), 64);
        chk("t1_overrun", int'(ov_a), 0);

        // Driver loopback with cutoff 0x7f: 127 high of a 256-cycle frame.
        gap();
        set_exp(127, 256);
        run_pwm(127, 129, 4);
        step(40);
        chk("t2_count", n_a, 3);
        chk("t2_duty_127_or_128", int'(duty_a == 8'd127 || duty_a == 8'd128), 1);

        // Line held high past TIMEOUT=200, then released.
        gap();
        exp_stuck = 1'b1;
        exp_lvl   = 1'b1;
        pwm_in    = 1'b1;
        step(200);
        chk("t3_not_yet_stuck", int'(st_a), 0);
        chk("t3_no_early_sample", n_a, 0);
        step(6);
        chk("t3_stuck", int'(st_a), 1);
        chk("t3_stuck_level", int'(sl_a), 1);
        chk("t3_stuck_duty", int'(duty_a), 255);
        chk("t3_stuck_period", int'(pc_a), 0);
        chk("t3_stuck_samples", n_a, 1);
        step(4);
        exp_stuck = 1'b0;
        pwm_in    = 1'b0;
        step(5);
        chk("t3_stuck_cleared", int'(st_a), 0);
        n_a = 0;
        set_exp(20, 50);
        run_pwm(20, 30, 3);
        step(40);
        chk("t3_resume_count", n_a, 2);
        chk("t3_resume_duty", int'(duty_a), 102);

        // Period 10 is shorter than the 25-cycle divide: completions at
        // +10 and +20 after an accepted start are dropped, +30 is accepted,
        // so 7 completed periods yield 3 results.
        gap();
        set_exp(5, 10);
        run_pwm(5, 5, 8);
        step(40);
        chk("t4_count", n_a, 3);
        chk("t4_duty", int'(duty_a), 128);
        chk("t4_high", int'(hc_a), 5);
        chk("t4_overrun", int'(ov_a), 1);

        // Reset while measuring the low phase.
        gap();
        set_exp(20, 50);
        pwm_in = 1'b1;
        step(20);
        pwm_in = 1'b0;
        step(10);
        reset = 1'b1;
        #1;
        chk("t5_high_cleared", int'(hc_a), 0);
        chk("t5_period_cleared", int'(pc_a), 0);
        chk("t5_duty_cleared", int'(duty_a), 0);
        chk("t5_overrun_cleared", int'(ov_a), 0);
        chk("t5_stuck_cleared", int'(st_a), 0);
        n_a = 0;
        step(3);
        reset = 1'b0;
        step(10);
        chk("t5_no_sample_after_release", n_a, 0);
        run_pwm(20, 30, 2);
        step(40);
        chk("t5_one_sample", n_a, 1);
        chk("t5_high", int'(hc_a), 20);
        chk("t5_overrun_stays_clear", int'(ov_a), 0);

        // Duty extremes on a 300-cycle period.
        arm_a = 1'b0;
        arm_b = 1'b1;
        gap();
        set_exp(1, 300);
        run_pwm(1, 299, 3);
        step(40);
        chk("t6_min_count", n_b, 2);
        chk("t6_min_duty", int'(duty_b), 0);
        chk("t6_min_high", int'(hc_b), 1);
        chk("t6_min_period", int'(pc_b), 300);
        gap();
        set_exp(299, 300);
        run_pwm(299, 1, 3);
        step(40);
        chk("t6_max_count", n_b, 2);
        chk("t6_max_duty", int'(duty_b), 255);
        chk("t6_max_high", int'(hc_b), 299);
        chk("t6_not_stuck", int'(st_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
